// File: rtl/gh18b20_onewire_master.sv
// 1-Wire master for the gh18b20 sensor: one conversion plus a 9-byte scratchpad read per start.
// Defining GH18B20_CRC_EN adds the Dallas CRC-8 check of the scratchpad (crc_err output).
module gh18b20_onewire_master #(
   parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
   parameter int unsigned CONV_WAIT_US = 750_000,
   parameter int unsigned RST_LOW_US   = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        dq_in,
   output logic        dq_oe,
   output logic        busy,
   output logic        data_valid,
   output logic [15:0] temp_raw,
   output logic [7:0]  th,
   output logic [7:0]  tl,
   output logic [7:0]  cfg,
   output logic        presence_err,
   output logic        crc_err
);

   localparam int unsigned TICK_DIV       = (CLK_FREQ_HZ / 1_000_000 > 1) ? CLK_FREQ_HZ / 1_000_000 : 1;
   localparam int unsigned DIV_W          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned US_W           = 20;
   localparam int unsigned PRES_SAMPLE_US = 120;
   localparam int unsigned RST_REL_US     = 480;
   localparam int unsigned SLOT_US        = 70;
   localparam int unsigned WR0_LOW_US     = 60;
   localparam int unsigned SHORT_LOW_US   = 2;
   localparam int unsigned RD_SAMPLE_US   = 12;
   localparam int unsigned GAP_US         = 10;
   localparam logic [7:0]  CMD_SKIP_ROM   = 8'hCC;
   localparam logic [7:0]  CMD_CONV       = 8'h44;
   localparam logic [7:0]  CMD_READ       = 8'hBE;

   typedef enum logic [3:0] {
      S_IDLE, S_RST_LOW, S_RST_REL, S_WR_BYTE, S_CONV_WAIT,
      S_GAP, S_RD_BYTE, S_DONE, S_ERR
   } state_t;

   state_t             state;
   logic [DIV_W-1:0]   div_cnt;
   logic               us_tick;
   logic [US_W-1:0]    us_cnt;
   logic               slot_end;
   logic               dq_meta;
   logic               dq_sync;
   logic               phase_read;
   logic               wr_skip;
   logic               present;
   logic [7:0]         tx_byte;
   logic [7:0]         rx_shift;
   logic [2:0]         bit_cnt;
   logic [3:0]         byte_cnt;
   logic [7:0]         stg_t0;
   logic [7:0]         stg_t1;
   logic [7:0]         stg_th;
   logic [7:0]         stg_tl;
   logic [7:0]         stg_cfg;

   assign us_tick  = (div_cnt == DIV_W'(TICK_DIV - 1));
   assign slot_end = us_tick && (us_cnt == US_W'(SLOT_US - 1));

`ifdef GH18B20_CRC_EN
   logic [7:0] crc_q;
   logic       crc_bad;
   logic       crc_err_q;

   assign crc_err = crc_err_q;

   // Dallas CRC-8, reflected polynomial 0x8C, one bit per call, LSB first
   function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
      logic fb;
      fb = c[0] ^ b;
      return {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
   endfunction
`else
   assign crc_err = 1'b0;
`endif

   // Free-running 1 us timebase
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          div_cnt <= '0;
      else if (us_tick) div_cnt <= '0;
      else              div_cnt <= div_cnt + DIV_W'(1);
   end

   // DQ pad synchronizer; idle line reads high through the pullup
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dq_meta <= 1'b1;
         dq_sync <= 1'b1;
      end else begin
         dq_meta <= dq_in;
         dq_sync <= dq_meta;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         us_cnt       <= '0;
         dq_oe        <= 1'b0;
         busy         <= 1'b0;
         data_valid   <= 1'b0;
         presence_err <= 1'b0;
         temp_raw     <= '0;
         th           <= '0;
         tl           <= '0;
         cfg          <= '0;
         phase_read   <= 1'b0;
         wr_skip      <= 1'b0;
         present      <= 1'b0;
         tx_byte      <= '0;
         rx_shift     <= '0;
         bit_cnt      <= '0;
         byte_cnt     <= '0;
         stg_t0       <= '0;
         stg_t1       <= '0;
         stg_th       <= '0;
         stg_tl       <= '0;
         stg_cfg      <= '0;
`ifdef GH18B20_CRC_EN
         crc_q        <= '0;
         crc_bad      <= 1'b0;
         crc_err_q    <= 1'b0;
`endif
      end else begin
         data_valid   <= 1'b0;
         presence_err <= 1'b0;
         dq_oe        <= 1'b0;
         if (us_tick) us_cnt <= us_cnt + US_W'(1);

         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_RST_LOW;
                  us_cnt     <= '0;
                  busy       <= 1'b1;
                  phase_read <= 1'b0;
                  bit_cnt    <= '0;
                  byte_cnt   <= '0;
`ifdef GH18B20_CRC_EN
                  crc_err_q  <= 1'b0;
`endif
               end
            end

            S_RST_LOW: begin
               dq_oe <= 1'b1;
               if (us_tick && us_cnt == US_W'(RST_LOW_US - 1)) begin
                  state   <= S_RST_REL;
                  us_cnt  <= '0;
                  present <= 1'b0;
               end
            end

            S_RST_REL: begin
               if (us_tick && us_cnt == US_W'(PRES_SAMPLE_US)) present <= ~dq_sync;
               if (us_tick && us_cnt == US_W'(RST_REL_US - 1)) begin
                  us_cnt <= '0;
                  if (present) begin
                     state   <= S_WR_BYTE;
                     tx_byte <= CMD_SKIP_ROM;
                     wr_skip <= 1'b1;
                  end else begin
                     state <= S_ERR;
                  end
               end
            end

            // Each write slot: a 1 is a short low pulse, a 0 holds the line low most of the slot
            S_WR_BYTE: begin
               dq_oe <= (us_cnt < (tx_byte[0] ? US_W'(SHORT_LOW_US) : US_W'(WR0_LOW_US)));
               if (slot_end) begin
                  us_cnt  <= '0;
                  bit_cnt <= bit_cnt + 3'd1;
                  tx_byte <= {1'b0, tx_byte[7:1]};
                  if (bit_cnt == 3'd7) begin
                     if (wr_skip) begin
                        wr_skip <= 1'b0;
                        tx_byte <= phase_read ? CMD_READ : CMD_CONV;
                     end else begin
                        state <= phase_read ? S_GAP : S_CONV_WAIT;
                     end
                  end
               end
            end

            S_CONV_WAIT: begin
               if (us_tick && us_cnt == US_W'(CONV_WAIT_US - 1)) begin
                  state      <= S_RST_LOW;
                  us_cnt     <= '0;
                  phase_read <= 1'b1;
                  bit_cnt    <= '0;
                  byte_cnt   <= '0;
               end
            end

            S_GAP: begin
               if (us_tick && us_cnt == US_W'(GAP_US - 1)) begin
                  state  <= S_RD_BYTE;
                  us_cnt <= '0;
`ifdef GH18B20_CRC_EN
                  crc_q  <= '0;
`endif
               end
            end

            S_RD_BYTE: begin
               dq_oe <= (us_cnt < US_W'(SHORT_LOW_US));
               if (us_tick && us_cnt == US_W'(RD_SAMPLE_US)) begin
                  rx_shift <= {dq_sync, rx_shift[7:1]};
`ifdef GH18B20_CRC_EN
                  if (byte_cnt != 4'd8) crc_q <= crc_step(crc_q, dq_sync);
`endif
               end
               if (slot_end) begin
                  us_cnt  <= '0;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     byte_cnt <= byte_cnt + 4'd1;
                     case (byte_cnt)
                        4'd0:    stg_t0  <= rx_shift;
                        4'd1:    stg_t1  <= rx_shift;
                        4'd2:    stg_th  <= rx_shift;
                        4'd3:    stg_tl  <= rx_shift;
                        4'd4:    stg_cfg <= rx_shift;
                        default: ;
                     endcase
                     if (byte_cnt == 4'd8) begin
                        state <= S_DONE;
`ifdef GH18B20_CRC_EN
                        crc_bad <= (rx_shift != crc_q);
`endif
                     end
                  end
               end
            end

            // Results are committed only here, so aborted runs leave them untouched
            S_DONE: begin
               temp_raw   <= {stg_t1, stg_t0};
               th         <= stg_th;
               tl         <= stg_tl;
               cfg        <= stg_cfg;
               data_valid <= 1'b1;
               busy       <= 1'b0;
               state      <= S_IDLE;
`ifdef GH18B20_CRC_EN
               crc_err_q  <= crc_bad;
`endif
            end

            S_ERR: begin
               presence_err <= 1'b1;
               busy         <= 1'b0;
               state        <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
